// File: rtl/atcu_cmd_tx.sv
// atcu_cmd_tx - AT-command transmitter for the GSM modem link.
//
// On an accepted request the selected AT command string is serialised byte by
// byte to the UART transmitter over a valid/ready handshake. The block then
// waits for the response parser's OK/ERROR verdict, resending on ERROR or
// timeout up to MAX_RETRY times, and finally pulses done with a status code.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   cmd_start        request strobe, taken only while cmd_ready=1
//   cmd_code         1 "AT\r", 2 "AT+CMGF=1\r", 3 "AT+CMGR=<n>\r", 4 "AT+CMGD=<n>\r"
//   message_no       SMS index n (1..99) for codes 3/4
//   cmd_ready        high only while idle
//   tx_data/tx_valid byte stream to the UART, held until tx_ready
//   tx_ready         UART accepts tx_data
//   resp_valid       one-cycle verdict strobe from the parser
//   resp_ctrl        verdict: 1=OK, 3=ERROR, others ignored
//   done             one-cycle completion pulse
//   status           0=OK 1=ERROR 2=TIMEOUT 3=BADCMD, valid from done onwards
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | ready for a command
// S_CHECK     | validate latched code / message number
// S_SEND      | present string[idx] until the UART takes it
// S_WAIT_RESP | wait for parser verdict or timeout, retry if allowed
// S_DONE      | one-cycle done pulse, status valid
module atcu_cmd_tx #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_start,
  input  logic [2:0] cmd_code,
  input  logic [7:0] message_no,
  output logic       cmd_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       resp_valid,
  input  logic [2:0] resp_ctrl,
  output logic       done,
  output logic [1:0] status
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SEND,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    code_q;
  logic [7:0]    num_q;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;

  logic          cmd_bad;
  logic [7:0]    first_byte;
  logic [7:0]    next_byte;
  logic          verdict_ok;
  logic          verdict_err;
  logic          timed_out;

  // Byte idx of the command string. Codes 3/4 share the "AT+CMG" prefix and
  // carry a one- or two-digit index without a leading zero.
  function automatic logic [7:0] char_at(input logic [2:0] code,
                                         input logic [7:0] n,
                                         input logic [3:0] i);
    logic [7:0] tens;
    logic [7:0] units;
    logic       two_dig;
    logic [7:0] c;
    tens    = n / 8'd10;
    units   = n % 8'd10;
    two_dig = (n >= 8'd10);
    c       = 8'h00;
    case (code)
      3'd1: begin
        case (i)
          4'd0:    c = 8'h41;
          4'd1:    c = 8'h54;
          default: c = CHAR_CR;
        endcase
      end
      3'd2: begin
        case (i)
          4'd0:    c = 8'h41;  // A
          4'd1:    c = 8'h54;  // T
          4'd2:    c = 8'h2B;  // +
          4'd3:    c = 8'h43;  // C
          4'd4:    c = 8'h4D;  // M
          4'd5:    c = 8'h47;  // G
          4'd6:    c = 8'h46;  // F
          4'd7:    c = 8'h3D;  // =
          4'd8:    c = 8'h31;  // 1
          default: c = CHAR_CR;
        endcase
      end
      3'd3, 3'd4: begin
        case (i)
          4'd0:    c = 8'h41;
          4'd1:    c = 8'h54;
          4'd2:    c = 8'h2B;
          4'd3:    c = 8'h43;
          4'd4:    c = 8'h4D;
          4'd5:    c = 8'h47;
          4'd6:    c = (code == 3'd3) ? 8'h52 : 8'h44;  // R / D
          4'd7:    c = 8'h3D;
          4'd8:    c = two_dig ? (8'h30 + tens) : (8'h30 + units);
          4'd9:    c = two_dig ? (8'h30 + units) : CHAR_CR;
          default: c = CHAR_CR;
        endcase
      end
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    cmd_bad = 1'b1;
    case (code_q)
      3'd1, 3'd2: cmd_bad = 1'b0;
      3'd3, 3'd4: cmd_bad = (num_q == 8'd0) || (num_q > 8'd99);
      default:    cmd_bad = 1'b1;
    endcase
  end

  assign first_byte  = char_at(code_q, num_q, 4'd0);
  assign next_byte   = char_at(code_q, num_q, idx + 4'd1);
  assign verdict_ok  = resp_valid && (resp_ctrl == 3'd1);
  assign verdict_err = resp_valid && (resp_ctrl == 3'd3);
  assign timed_out   = (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      done      <= 1'b0;
      status    <= 2'd0;
      code_q    <= 3'd0;
      num_q     <= 8'd0;
      idx       <= 4'd0;
      timer     <= '0;
      retry     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            code_q    <= cmd_code;
            num_q     <= message_no;
            retry     <= '0;
            cmd_ready <= 1'b0;
            state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cmd_bad) begin
            done   <= 1'b1;
            status <= 2'd3;
            state  <= S_DONE;
          end else begin
            idx      <= 4'd0;
            tx_data  <= first_byte;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (tx_ready) begin
            // CR only ever appears as the terminating byte.
            if (tx_data == CHAR_CR) begin
              tx_valid <= 1'b0;
              timer    <= '0;
              state    <= S_WAIT_RESP;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= next_byte;
            end
          end
        end

        S_WAIT_RESP: begin
          // A verdict takes priority over a timeout in the same cycle.
          if (verdict_ok) begin
            done   <= 1'b1;
            status <= 2'd0;
            state  <= S_DONE;
          end else if (verdict_err || timed_out) begin
            if (retry < RETRY_MAX) begin
              retry    <= retry + 1'b1;
              idx      <= 4'd0;
              tx_data  <= first_byte;
              tx_valid <= 1'b1;
              state    <= S_SEND;
            end else begin
              done   <= 1'b1;
              status <= verdict_err ? 2'd1 : 2'd2;
              state  <= S_DONE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          tx_valid  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atcu_cmd_tx.sv
// tb_atcu_cmd_tx - directed self-checking bench for atcu_cmd_tx.
// The DUT runs with MAX_RETRY=1 and TIMEOUT_CYCLES=50 so retry and timeout
// paths complete in a short run. Inputs change and outputs are sampled 1 ns
// after each rising clock edge.
module tb_atcu_cmd_tx;

  localparam int TO = 50;

  logic       clk;
  logic       rst;
  logic       cmd_start;
  logic [2:0] cmd_code;
  logic [7:0] message_no;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       resp_valid;
  logic [2:0] resp_ctrl;
  logic       done;
  logic [1:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  atcu_cmd_tx #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .cmd_code   (cmd_code),
    .message_no (message_no),
    .cmd_ready  (cmd_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .resp_valid (resp_valid),
    .resp_ctrl  (resp_ctrl),
    .done       (done),
    .status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; returns one cycle after the DUT has entered SEND.
  task automatic start_cmd(input logic [2:0] code, input logic [7:0] n, input string tag);
    cmd_code   = code;
    message_no = n;
    cmd_start  = 1'b1;
    tick();
    cmd_start = 1'b0;
    chk({tag, " busy"}, cmd_ready, 1'b0);
    chk({tag, " no valid in check"}, tx_valid, 1'b0);
    tick();
  endtask

  task automatic send_expect(input logic [7:0] exp[$], input bit toggle, input string tag);
    int         got;
    int         cyc;
    bit         stalled;
    logic [7:0] prev;
    got = 0; cyc = 0; stalled = 0; prev = 8'h00;
    while (got < exp.size() && cyc < 100) begin
      tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (tx_valid) begin
        if (stalled) chk($sformatf("%s hold%0d", tag, got), tx_data, prev);
        if (tx_ready) begin
          chk($sformatf("%s byte%0d", tag, got), tx_data, exp[got]);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev    = tx_data;
        end
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    chk({tag, " count"}, got, exp.size());
    if (!toggle) chk({tag, " cycles"}, cyc, exp.size());
    chk({tag, " valid drop"}, tx_valid, 1'b0);
  endtask

  task automatic resp_done(input logic [2:0] ctrl, input logic [1:0] exp_status, input string tag);
    resp_valid = 1'b1;
    resp_ctrl  = ctrl;
    tick();
    resp_valid = 1'b0;
    resp_ctrl  = 3'd0;
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " status"}, status, exp_status);
    chk({tag, " not ready in done"}, cmd_ready, 1'b0);
    tick();
    chk({tag, " done one cycle"}, done, 1'b0);
    chk({tag, " ready after"}, cmd_ready, 1'b1);
    chk({tag, " status held"}, status, exp_status);
  endtask

  logic [7:0] s_at[$];
  logic [7:0] s_cmgf[$];
  logic [7:0] s_cmgr7[$];
  logic [7:0] s_cmgd12[$];
  logic [2:0] bad_code[3];
  logic [7:0] bad_num[3];

  initial begin
    int n;
    s_at     = '{8'h41, 8'h54, 8'h0D};
    s_cmgf   = '{8'h41, 8'h54, 8'h2B, 8'h43, 8'h4D, 8'h47, 8'h46, 8'h3D, 8'h31, 8'h0D};
    s_cmgr7  = '{8'h41, 8'h54, 8'h2B, 8'h43, 8'h4D, 8'h47, 8'h52, 8'h3D, 8'h37, 8'h0D};
    s_cmgd12 = '{8'h41, 8'h54, 8'h2B, 8'h43, 8'h4D, 8'h47, 8'h44, 8'h3D, 8'h31, 8'h32, 8'h0D};
    bad_code = '{3'd0, 3'd3, 3'd4};
    bad_num  = '{8'd5, 8'd0, 8'd100};

    rst = 1'b1; cmd_start = 1'b0; cmd_code = 3'd0; message_no = 8'd0;
    tx_ready = 1'b1; resp_valid = 1'b0; resp_ctrl = 3'd0;
    tick(); tick();
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst done", done, 1'b0);
    chk("rst status", status, 2'd0);
    rst = 1'b0;
    tick();

    // Basic "AT\r" with OK.
    start_cmd(3'd1, 8'd0, "at");
    send_expect(s_at, 1'b0, "at");
    resp_done(3'd1, 2'd0, "at ok");

    // Single-digit index; an unrelated parser code must be ignored.
    start_cmd(3'd3, 8'd7, "cmgr7");
    send_expect(s_cmgr7, 1'b0, "cmgr7");
    resp_valid = 1'b1; resp_ctrl = 3'd2;
    tick();
    resp_valid = 1'b0; resp_ctrl = 3'd0;
    chk("ignored ctrl done", done, 1'b0);
    chk("ignored ctrl valid", tx_valid, 1'b0);
    resp_done(3'd1, 2'd0, "cmgr7 ok");

    // Two-digit index.
    start_cmd(3'd4, 8'd12, "cmgd12");
    send_expect(s_cmgd12, 1'b0, "cmgd12");
    resp_done(3'd1, 2'd0, "cmgd12 ok");

    // Back-pressure: tx_ready toggling.
    start_cmd(3'd2, 8'd0, "cmgf");
    send_expect(s_cmgf, 1'b1, "cmgf");
    resp_done(3'd1, 2'd0, "cmgf ok");

    // ERROR twice: one resend, then status ERROR.
    start_cmd(3'd1, 8'd0, "err");
    send_expect(s_at, 1'b0, "err send1");
    resp_valid = 1'b1; resp_ctrl = 3'd3;
    tick();
    resp_valid = 1'b0; resp_ctrl = 3'd0;
    chk("err resend valid", tx_valid, 1'b1);
    chk("err no done", done, 1'b0);
    send_expect(s_at, 1'b0, "err send2");
    resp_done(3'd3, 2'd1, "err final");

    // No response: two sends each followed by a TO-cycle wait.
    start_cmd(3'd1, 8'd0, "to");
    send_expect(s_at, 1'b0, "to send1");
    n = 0;
    while (!tx_valid && n < 200) begin tick(); n++; end
    chk("to wait1 cycles", n, TO);
    send_expect(s_at, 1'b0, "to send2");
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("to wait2 cycles", n, TO);
    chk("to status", status, 2'd2);
    tick();
    chk("to ready after", cmd_ready, 1'b1);

    // OK arriving on the timeout cycle wins.
    start_cmd(3'd1, 8'd0, "race");
    send_expect(s_at, 1'b0, "race");
    repeat (TO - 1) tick();
    chk("race no early done", done, 1'b0);
    resp_done(3'd1, 2'd0, "race ok");

    // Bad commands.
    for (int k = 0; k < 3; k++) begin
      cmd_code = bad_code[k]; message_no = bad_num[k]; cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      chk($sformatf("bad%0d valid check", k), tx_valid, 1'b0);
      tick();
      chk($sformatf("bad%0d done", k), done, 1'b1);
      chk($sformatf("bad%0d status", k), status, 2'd3);
      chk($sformatf("bad%0d valid done", k), tx_valid, 1'b0);
      tick();
      chk($sformatf("bad%0d ready", k), cmd_ready, 1'b1);
    end

    // Reset after the fourth byte of "AT+CMGF=1\r".
    start_cmd(3'd2, 8'd0, "rstmid");
    repeat (4) tick();
    chk("rstmid byte4", tx_data, 8'h4D);
    chk("rstmid valid pre", tx_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid async valid", tx_valid, 1'b0);
    chk("rstmid async ready", cmd_ready, 1'b1);
    chk("rstmid no done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid done after", done, 1'b0);
    start_cmd(3'd1, 8'd0, "post");
    send_expect(s_at, 1'b0, "post");
    resp_done(3'd1, 2'd0, "post ok");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
